fluid_board_timer_host: RTL and testbench

//  Avalon-MM initiator that drives the 16-bit interval-timer slave on the fluid board (3-bit word address, no waitrequest, registered readdata).

---
 rtl/fluid_timer_pkg.sv | 55 +++++
 rtl/fluid_board_tick_counter.sv | 24 ++
 rtl/fluid_board_timer_host.sv | 190 +++++++++++++++++++
 tb/tb_fluid_board_timer_host.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fluid_timer_pkg.sv
// Shared definitions for the fluid board interval-timer host: slave register map,
// control bit positions, command opcodes and the sequencer state encoding.
package fluid_timer_pkg;

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIODL = 3'd2;
    localparam logic [2:0] REG_PERIODH = 3'd3;
    localparam logic [2:0] REG_SNAPL   = 3'd4;
    localparam logic [2:0] REG_SNAPH   = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    typedef enum logic [1:0] {
        OP_PROGRAM  = 2'd0,
        OP_STOP     = 2'd1,
        OP_SNAPSHOT = 2'd2,
        OP_RESERVED = 2'd3
    } cmd_op_t;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_PL   = 4'd1,
        ST_WR_PH   = 4'd2,
        ST_WR_CTRL = 4'd3,
        ST_WR_STOP = 4'd4,
        ST_WR_SNAP = 4'd5,
        ST_RD_SL   = 4'd6,
        ST_RD_SH   = 4'd7,
        ST_CLR_ST  = 4'd8,
        ST_RSP     = 4'd9
    } state_t;

    typedef struct packed {
        logic        chipselect;
        logic        write_n;
        logic [2:0]  address;
        logic [15:0] writedata;
    } bus_t;

    function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                              input logic cont, input logic ito);
        logic [15:0] w;
        w             = '0;
        w[CTRL_STOP]  = stop;
        w[CTRL_START] = start;
        w[CTRL_CONT]  = cont;
        w[CTRL_ITO]   = ito;
        return w;
    endfunction

endpackage

// File: rtl/fluid_board_tick_counter.sv
// One-cycle tick pulse and wrapping count of serviced timer interrupts.
module fluid_board_tick_counter #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_en,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_pulse <= 1'b0;
            tick_count <= '0;
        end else begin
            tick_pulse <= tick_en;
            if (tick_en) begin
                tick_count <= tick_count + TICK_W'(1);
            end
        end
    end

endmodule

// File: rtl/fluid_board_timer_host.sv
// Avalon-MM initiator for the fluid board interval timer: turns local commands into
// register sequences and services the timeout interrupt.
module fluid_board_timer_host
    import fluid_timer_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int TICK_W       = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [31:0]       cmd_period,
    input  logic              cmd_continuous,
    input  logic              cmd_irq_en,
    output logic              rsp_valid,
    output logic [31:0]       rsp_data,
    output logic              tick_pulse,
    output logic [TICK_W-1:0] tick_count,
    output logic              busy,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq,
    output logic [3:0]        fsm_state
);

    localparam int RD_CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // cmd_* are sampled only on that edge. rsp_valid is a one-cycle pulse with no back-pressure.
    state_t              state;
    state_t              state_next;
    bus_t                bus_q;
    bus_t                bus_next;
    logic                accept;
    logic [31:0]         period_q;
    logic [31:0]         period_d;
    logic                cont_q;
    logic                cont_d;
    logic                ito_q;
    logic                ito_d;
    logic [RD_CNT_W-1:0] rd_cnt;
    logic                rd_last;
    logic                in_read;
    logic [15:0]         snap_lo;
    logic                rsp_valid_next;
    logic [31:0]         rsp_data_next;
    logic                tick_en;

    assign accept    = (state == ST_IDLE) && cmd_valid && !timer_irq;
    assign cmd_ready = (state == ST_IDLE) && !timer_irq;
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    // Bus registers are loaded from the upcoming state, so the captured command has to be
    // visible on the accept edge itself.
    assign period_d = accept ? cmd_period     : period_q;
    assign cont_d   = accept ? cmd_continuous : cont_q;
    assign ito_d    = accept ? cmd_irq_en     : ito_q;

    assign in_read = (state == ST_RD_SL) || (state == ST_RD_SH);
    assign rd_last = (rd_cnt == RD_CNT_W'(READ_LATENCY));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (timer_irq) begin
                    state_next = ST_CLR_ST;
                end else if (cmd_valid) begin
                    case (cmd_op_t'(cmd_op))
                        OP_PROGRAM:  state_next = ST_WR_PL;
                        OP_STOP:     state_next = ST_WR_STOP;
                        OP_SNAPSHOT: state_next = ST_WR_SNAP;
                        default:     state_next = ST_RSP;
                    endcase
                end
            end
            ST_WR_PL:   state_next = ST_WR_PH;
            ST_WR_PH:   state_next = ST_WR_CTRL;
            ST_WR_CTRL: state_next = ST_RSP;
            ST_WR_STOP: state_next = ST_RSP;
            ST_WR_SNAP: state_next = ST_RD_SL;
            ST_RD_SL:   if (rd_last) state_next = ST_RD_SH;
            ST_RD_SH:   if (rd_last) state_next = ST_RSP;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus_next.chipselect = 1'b1;
        bus_next.write_n    = 1'b0;
        bus_next.address    = REG_STATUS;
        bus_next.writedata  = '0;
        case (state_next)
            ST_WR_PL: begin
                bus_next.address   = REG_PERIODL;
                bus_next.writedata = period_d[15:0];
            end
            ST_WR_PH: begin
                bus_next.address   = REG_PERIODH;
                bus_next.writedata = period_d[31:16];
            end
            ST_WR_CTRL: begin
                bus_next.address   = REG_CONTROL;
                bus_next.writedata = ctrl_word(1'b0, 1'b1, cont_d, ito_d);
            end
            ST_WR_STOP: begin
                bus_next.address   = REG_CONTROL;
                bus_next.writedata = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
            end
            ST_WR_SNAP: bus_next.address = REG_SNAPL;
            ST_RD_SL: begin
                bus_next.write_n = 1'b1;
                bus_next.address = REG_SNAPL;
            end
            ST_RD_SH: begin
                bus_next.write_n = 1'b1;
                bus_next.address = REG_SNAPH;
            end
            ST_CLR_ST: bus_next.address = REG_STATUS;
            default: begin
                bus_next.chipselect = 1'b0;
                bus_next.write_n    = 1'b1;
            end
        endcase
    end

    // Only the SNAPSHOT path reaches RSP from RD_SH; the high word is taken straight off the bus.
    assign rsp_valid_next = (state_next == ST_RSP);
    assign rsp_data_next  = ((state == ST_RD_SH) && (state_next == ST_RSP)) ?
                            {avm_readdata, snap_lo} : 32'h0;
    assign tick_en        = (state_next == ST_CLR_ST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_q     <= '{chipselect: 1'b0, write_n: 1'b1, address: 3'd0, writedata: 16'h0};
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            period_q  <= '0;
            cont_q    <= 1'b0;
            ito_q     <= 1'b0;
            rd_cnt    <= '0;
            snap_lo   <= '0;
        end else begin
            bus_q     <= bus_next;
            rsp_valid <= rsp_valid_next;
            rsp_data  <= rsp_data_next;
            period_q  <= period_d;
            cont_q    <= cont_d;
            ito_q     <= ito_d;
            if (in_read && (state_next == state)) begin
                rd_cnt <= rd_cnt + RD_CNT_W'(1);
            end else begin
                rd_cnt <= '0;
            end
            if ((state == ST_RD_SL) && rd_last) begin
                snap_lo <= avm_readdata;
            end
        end
    end

    assign avm_chipselect = bus_q.chipselect;
    assign avm_write_n    = bus_q.write_n;
    assign avm_address    = bus_q.address;
    assign avm_writedata  = bus_q.writedata;

    fluid_board_tick_counter #(
        .TICK_W(TICK_W)
    ) u_tick_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick_en    (tick_en),
        .tick_pulse (tick_pulse),
        .tick_count (tick_count)
    );

endmodule

// File: tb/tb_fluid_board_timer_host.sv
// Directed bench for fluid_board_timer_host paired with a behavioural interval-timer slave.
module tb_fluid_board_timer_host;
    import fluid_timer_pkg::*;

    localparam int TICK_W = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [31:0]       cmd_period = '0;
    logic              cmd_continuous = 1'b0;
    logic              cmd_irq_en = 1'b0;
    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic              tick_pulse;
    logic [TICK_W-1:0] tick_count;
    logic              busy;
    logic [2:0]        avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic [15:0]       avm_writedata;
    logic [15:0]       avm_readdata;
    logic              timer_irq;
    logic [3:0]        fsm_state;

    int pass_cnt = 0;
    int total_cnt = 0;
    int exp_ticks = 0;
    int clr_writes = 0;
    int clr_base;
    int cyc;
    int n;
    logic irq_seen;

    always #5 clk = ~clk;

    fluid_board_timer_host #(
        .READ_LATENCY(1),
        .TICK_W(TICK_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_period     (cmd_period),
        .cmd_continuous (cmd_continuous),
        .cmd_irq_en     (cmd_irq_en),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .tick_pulse     (tick_pulse),
        .tick_count     (tick_count),
        .busy           (busy),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_write_n    (avm_write_n),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .timer_irq      (timer_irq),
        .fsm_state      (fsm_state)
    );

    // Interval-timer slave model: counts period+1 clocks, registered readdata.
    logic [31:0] s_period = '0;
    logic [31:0] s_cnt = '0;
    logic [31:0] s_snap = '0;
    logic        s_run = 1'b0;
    logic        s_to = 1'b0;
    logic        s_ito = 1'b0;
    logic        s_cont = 1'b0;
    logic [15:0] s_rdata = '0;

    assign avm_readdata = s_rdata;
    assign timer_irq    = s_to & s_ito;

    always @(posedge clk) begin
        if (s_run) begin
            if (s_cnt == 0) begin
                s_to  <= 1'b1;
                s_cnt <= s_period;
                if (!s_cont) s_run <= 1'b0;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
        if (avm_chipselect && !avm_write_n) begin
            case (avm_address)
                3'd0: s_to <= 1'b0;
                3'd1: begin
                    s_ito  <= avm_writedata[0];
                    s_cont <= avm_writedata[1];
                    if (avm_writedata[3]) s_run <= 1'b0;
                    else if (avm_writedata[2]) s_run <= 1'b1;
                end
                3'd2: begin
                    s_period[15:0] <= avm_writedata;
                    s_cnt          <= {s_period[31:16], avm_writedata};
                    s_run          <= 1'b0;
                end
                3'd3: begin
                    s_period[31:16] <= avm_writedata;
                    s_cnt           <= {avm_writedata, s_period[15:0]};
                    s_run           <= 1'b0;
                end
                3'd4, 3'd5: s_snap <= s_cnt;
                default: ;
            endcase
        end
        if (avm_chipselect && avm_write_n) begin
            case (avm_address)
                3'd0:    s_rdata <= {14'b0, s_run, s_to};
                3'd1:    s_rdata <= {12'b0, 2'b00, s_cont, s_ito};
                3'd2:    s_rdata <= s_period[15:0];
                3'd3:    s_rdata <= s_period[31:16];
                3'd4:    s_rdata <= s_snap[15:0];
                3'd5:    s_rdata <= s_snap[31:16];
                default: s_rdata <= 16'h0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (avm_chipselect && !avm_write_n && avm_address == 3'd0) clr_writes++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    endtask

    task automatic check_bus(input string tag, input logic [2:0] addr, input logic [15:0] wd,
                             input logic wn);
        check(tag, {11'b0, avm_chipselect, avm_write_n, avm_address, avm_writedata},
              {11'b0, 1'b1, wn, addr, wd});
    endtask

    // Returns at the negedge of the first cycle after the accept edge.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] p, input logic c,
                            input logic i);
        int k;
        k = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_period = p; cmd_continuous = c; cmd_irq_en = i;
        while (!cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = '0; cmd_continuous = 1'b0; cmd_irq_en = 1'b0;
    endtask

    task automatic program_seq(input logic [31:0] p, input logic c, input logic i);
        send_cmd(OP_PROGRAM, p, c, i);
        check_bus("prog_pl", 3'd2, p[15:0], 1'b0);
        @(negedge clk);
        check_bus("prog_ph", 3'd3, p[31:16], 1'b0);
        @(negedge clk);
        check_bus("prog_ctrl", 3'd1, {12'b0, 1'b0, 1'b1, c, i}, 1'b0);
        @(negedge clk);
        check("prog_rsp", {rsp_valid, avm_chipselect, rsp_data[29:0]}, {2'b10, 30'h0});
    endtask

    task automatic stop_seq();
        send_cmd(OP_STOP, 32'h0, 1'b0, 1'b0);
        check_bus("stop_wr", 3'd1, 16'h0008, 1'b0);
        @(negedge clk);
        check("stop_rsp", {rsp_valid, avm_chipselect, rsp_data[29:0]}, {2'b10, 30'h0});
    endtask

    task automatic wait_tick(input int bound, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!tick_pulse && cycles < bound);
        check("tick_seen", tick_pulse, 1);
        check_bus("clr_wr", 3'd0, 16'h0, 1'b0);
        exp_ticks++;
        check("tick_count", tick_count, exp_ticks % 16);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_bus", {avm_chipselect, avm_write_n, avm_address, avm_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
        check("rst_misc", {cmd_ready, busy, rsp_valid, tick_pulse, fsm_state}, {4'b1000, 4'd0});
        check("rst_data", {rsp_data[27:0], tick_count}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // PROGRAM with a 32-bit period, then STOP
        program_seq(32'h0001_86A0, 1'b1, 1'b1);
        stop_seq();

        // Reserved opcode: immediate response, no bus access
        send_cmd(OP_RESERVED, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("rsvd_rsp", {rsp_valid, avm_chipselect, avm_write_n, rsp_data[28:0]}, {3'b101, 29'h0});

        // Periodic interrupt every 10 clocks
        clr_base = clr_writes;
        program_seq(32'd9, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_tick(40, cyc);
            if (i > 0) check("tick_interval", cyc, 10);
        end
        stop_seq();
        check("clr_write_count", clr_writes - clr_base, 3);

        // SNAPSHOT after 100 clocks of a 1000-period run
        program_seq(32'd1000, 1'b1, 1'b0);
        repeat (100) @(negedge clk);
        send_cmd(OP_SNAPSHOT, 32'h0, 1'b0, 1'b0);
        check_bus("snap_wr", 3'd4, 16'h0, 1'b0);
        @(negedge clk); check_bus("snap_rl0", 3'd4, 16'h0, 1'b1);
        @(negedge clk); check_bus("snap_rl1", 3'd4, 16'h0, 1'b1);
        @(negedge clk); check_bus("snap_rh0", 3'd5, 16'h0, 1'b1);
        @(negedge clk); check_bus("snap_rh1", 3'd5, 16'h0, 1'b1);
        @(negedge clk);
        check("snap_rsp_valid", rsp_valid, 1);
        check("snap_hi", rsp_data[31:16], 0);
        check("snap_vs_slave", rsp_data, s_snap);
        check("snap_near_900", (rsp_data >= 32'd897 && rsp_data <= 32'd903), 1);
        stop_seq();

        // irq and STOP arriving together: clear first, STOP after
        program_seq(32'd9, 1'b1, 1'b1);
        n = 0;
        while (!timer_irq && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t4_irq_up", timer_irq, 1);
        cmd_valid = 1'b1; cmd_op = OP_STOP;
        check("t4_ready_low", cmd_ready, 0);
        @(negedge clk);
        check_bus("t4_clr", 3'd0, 16'h0, 1'b0);
        exp_ticks++;
        check("t4_tick", {tick_pulse, 3'b0, tick_count}, {1'b1, 3'b0, 4'(exp_ticks)});
        check("t4_ready_clr", cmd_ready, 0);
        @(negedge clk);
        check("t4_irq_dropped", {timer_irq, cmd_ready}, 2'b01);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'd0;
        check_bus("t4_stop_wr", 3'd1, 16'h0008, 1'b0);
        @(negedge clk);
        check("t4_rsp", rsp_valid, 1);
        irq_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            irq_seen = irq_seen | timer_irq;
        end
        check("t4_irq_quiet", irq_seen, 0);

        // Reset right after the PERIODL write aborts the sequence
        send_cmd(OP_PROGRAM, 32'd50, 1'b1, 1'b0);
        check_bus("t6_pl", 3'd2, 16'd50, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_abort", {avm_chipselect, avm_write_n, busy, rsp_valid, tick_count}, {4'b0100, 4'h0});
        repeat (3) begin
            @(negedge clk);
            check("t6_no_rsp", rsp_valid, 0);
        end
        reset_n = 1'b1;
        exp_ticks = 0;
        @(negedge clk);

        // Fresh PROGRAM after reset; 4-bit tick counter wraps after 16 ticks
        program_seq(32'd2, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            wait_tick(20, cyc);
            if (i > 0) check("t5_interval", cyc, 3);
        end
        check("t5_wrap", tick_count, 0);
        stop_seq();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
